// File: rtl/ps2_pkg.sv
// Shared constants and FSM encoding for the PS/2 scan-code sequencing controller.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_ERR0  = 8'h00;
  localparam logic [7:0] PS2_ERR1  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    POP    = 2'd1,
    SETTLE = 2'd2
  } ps2_state_e;

endpackage

// File: rtl/ps2_prefix_decode.sv
// Classifies one set-2 byte against the pending E0/F0 prefix flags and
// produces the updated flags plus the event fields a code byte would carry.
module ps2_prefix_decode
  import ps2_pkg::*;
(
  input  logic [7:0] byte_i,
  input  logic       ext_i,
  input  logic       brk_i,
  output logic       is_prefix_o,
  output logic       is_err_o,
  output logic       ext_o,
  output logic       brk_o,
  output logic [7:0] ev_code_o,
  output logic       ev_ext_o,
  output logic       ev_brk_o
);

  // Prefixes accumulate in either order; errors and code bytes both end the sequence.
  always_comb begin
    is_prefix_o = 1'b0;
    is_err_o    = 1'b0;
    ext_o       = 1'b0;
    brk_o       = 1'b0;
    ev_code_o   = byte_i;
    ev_ext_o    = ext_i;
    ev_brk_o    = brk_i;
    case (byte_i)
      PS2_EXT: begin
        is_prefix_o = 1'b1;
        ext_o       = 1'b1;
        brk_o       = brk_i;
      end
      PS2_BREAK: begin
        is_prefix_o = 1'b1;
        ext_o       = ext_i;
        brk_o       = 1'b1;
      end
      PS2_ERR0, PS2_ERR1: begin
        is_err_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: rtl/ps2_scan_ctrl.sv
// Pops bytes from the ps2_keyboard FIFO, folds prefixes into single key events,
// tracks the held key and press count, and raises sticky error/overflow flags.
module ps2_scan_ctrl
  import ps2_pkg::*;
#(
  parameter int CNT_W           = 8,
  parameter bit SUPPRESS_REPEAT = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       kb_data,
  input  logic             kb_ready,
  input  logic             kb_overflow,
  output logic             kb_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic             held_valid,
  output logic [8:0]       held_code,
  output logic [CNT_W-1:0] press_cnt,
  output logic             err_sticky,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  ps2_state_e       state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_q, ext_d;
  logic             brk_q, brk_d;
  logic             ev_valid_q, ev_valid_d;
  logic [7:0]       ev_code_q, ev_code_d;
  logic             ev_ext_q, ev_ext_d;
  logic             ev_brk_q, ev_brk_d;
  logic             held_valid_q, held_valid_d;
  logic [8:0]       held_code_q, held_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             ovf_q, ovf_d;
  logic             err_set;

  logic       dec_prefix, dec_err, dec_ext, dec_brk;
  logic [7:0] dec_code;
  logic       dec_ev_ext, dec_ev_brk;
  logic [8:0] dec_key;
  logic       is_repeat;

  ps2_prefix_decode u_decode (
    .byte_i      (byte_q),
    .ext_i       (ext_q),
    .brk_i       (brk_q),
    .is_prefix_o (dec_prefix),
    .is_err_o    (dec_err),
    .ext_o       (dec_ext),
    .brk_o       (dec_brk),
    .ev_code_o   (dec_code),
    .ev_ext_o    (dec_ev_ext),
    .ev_brk_o    (dec_ev_brk)
  );

  assign dec_key   = {dec_ev_ext, dec_code};
  assign is_repeat = SUPPRESS_REPEAT && held_valid_q && (held_code_q == dec_key);

  // A pending event blocks the next capture, so back-pressure reaches the FIFO.
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    ext_d        = ext_q;
    brk_d        = brk_q;
    ev_valid_d   = ev_valid_q;
    ev_code_d    = ev_code_q;
    ev_ext_d     = ev_ext_q;
    ev_brk_d     = ev_brk_q;
    held_valid_d = held_valid_q;
    held_code_d  = held_code_q;
    cnt_d        = cnt_q;
    err_set      = 1'b0;
    kb_nextdata_n = 1'b1;

    if (ev_valid_q && ev_ready) begin
      ev_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (kb_ready && !ev_valid_q) begin
          byte_d  = kb_data;
          state_d = POP;
        end
      end
      POP: begin
        kb_nextdata_n = 1'b0;
        state_d       = SETTLE;
        ext_d         = dec_ext;
        brk_d         = dec_brk;
        if (dec_err) begin
          err_set = 1'b1;
        end else if (!dec_prefix) begin
          if (!dec_ev_brk) begin
            if (!is_repeat) begin
              ev_valid_d   = 1'b1;
              ev_code_d    = dec_code;
              ev_ext_d     = dec_ev_ext;
              ev_brk_d     = 1'b0;
              cnt_d        = cnt_q + CNT_W'(1);
              held_valid_d = 1'b1;
              held_code_d  = dec_key;
            end
          end else begin
            ev_valid_d = 1'b1;
            ev_code_d  = dec_code;
            ev_ext_d   = dec_ev_ext;
            ev_brk_d   = 1'b1;
            if (held_code_q == dec_key) begin
              held_valid_d = 1'b0;
            end
          end
        end
      end
      SETTLE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A set on the same cycle as a clear must win.
    err_d = err_set | (err_q & ~clr_sticky);
    ovf_d = kb_overflow | (ovf_q & ~clr_sticky);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q      <= IDLE;
      byte_q       <= 8'h00;
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      ev_valid_q   <= 1'b0;
      ev_code_q    <= 8'h00;
      ev_ext_q     <= 1'b0;
      ev_brk_q     <= 1'b0;
      held_valid_q <= 1'b0;
      held_code_q  <= 9'h000;
      cnt_q        <= '0;
      err_q        <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      ext_q        <= ext_d;
      brk_q        <= brk_d;
      ev_valid_q   <= ev_valid_d;
      ev_code_q    <= ev_code_d;
      ev_ext_q     <= ev_ext_d;
      ev_brk_q     <= ev_brk_d;
      held_valid_q <= held_valid_d;
      held_code_q  <= held_code_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      ovf_q        <= ovf_d;
    end
  end

  assign ev_valid   = ev_valid_q;
  assign ev_code    = ev_code_q;
  assign ev_ext     = ev_ext_q;
  assign ev_break   = ev_brk_q;
  assign held_valid = held_valid_q;
  assign held_code  = held_code_q;
  assign press_cnt  = cnt_q;
  assign err_sticky = err_q;
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_ps2_scan_ctrl.sv
// Bench for ps2_scan_ctrl: a queue-backed FIFO feeds bytes, and a transaction
// model of the set-2 parsing rules predicts events, held key, count and flags.
module tb_ps2_scan_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             clrn = 1'b0;
  logic [7:0]       kb_data = 8'h00;
  logic             kb_ready = 1'b0;
  logic             kb_overflow = 1'b0;
  logic             kb_nextdata_n;
  logic             ev_valid;
  logic             ev_ready = 1'b0;
  logic [7:0]       ev_code;
  logic             ev_ext;
  logic             ev_break;
  logic             held_valid;
  logic [8:0]       held_code;
  logic [CNT_W-1:0] press_cnt;
  logic             err_sticky;
  logic             ovf_sticky;
  logic             clr_sticky = 1'b0;

  always #5 clk = ~clk;

  ps2_scan_ctrl #(.CNT_W(CNT_W), .SUPPRESS_REPEAT(1'b1)) dut (
    .clk           (clk),
    .clrn          (clrn),
    .kb_data       (kb_data),
    .kb_ready      (kb_ready),
    .kb_overflow   (kb_overflow),
    .kb_nextdata_n (kb_nextdata_n),
    .ev_valid      (ev_valid),
    .ev_ready      (ev_ready),
    .ev_code       (ev_code),
    .ev_ext        (ev_ext),
    .ev_break      (ev_break),
    .held_valid    (held_valid),
    .held_code     (held_code),
    .press_cnt     (press_cnt),
    .err_sticky    (err_sticky),
    .ovf_sticky    (ovf_sticky),
    .clr_sticky    (clr_sticky)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] fifo [$];
  logic [9:0] expQ [$];
  logic [7:0] byteTable [12] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h75, 8'h6B,
                                 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h00, 8'hFF};

  logic             mExt, mBrk, mHeldV, mErr, mOvf;
  logic [8:0]       mHeld;
  logic [CNT_W-1:0] mCnt;

  logic       popSeen = 1'b0, prevPop = 1'b0, prevHold = 1'b0, prevXfer = 1'b0;
  logic [9:0] holdFields = '0;
  logic [9:0] lastEv = '0;
  int         evCount = 0, popCount = 0;
  int         readyMode = 0;
  logic       ovfReq = 1'b0, clrReq = 1'b0, ovfApplied = 1'b0, clrApplied = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    mExt = 1'b0; mBrk = 1'b0; mHeldV = 1'b0; mErr = 1'b0; mOvf = 1'b0;
    mHeld = 9'h000; mCnt = '0;
    expQ.delete();
    fifo.delete();
  endtask

  // Whole-byte meaning of the set-2 stream, one byte at a time.
  task automatic modelByte(input logic [7:0] b);
    logic [8:0] key;
    if (b == 8'hE0) mExt = 1'b1;
    else if (b == 8'hF0) mBrk = 1'b1;
    else if (b == 8'h00 || b == 8'hFF) begin
      mErr = 1'b1; mExt = 1'b0; mBrk = 1'b0;
    end else begin
      key = {mExt, b};
      if (!mBrk) begin
        if (!(mHeldV && mHeld == key)) begin
          expQ.push_back({b, mExt, 1'b0});
          mCnt = mCnt + 1'b1;
          mHeldV = 1'b1;
          mHeld = key;
        end
      end else begin
        expQ.push_back({b, mExt, 1'b1});
        if (mHeldV && mHeld == key) mHeldV = 1'b0;
      end
      mExt = 1'b0; mBrk = 1'b0;
    end
  endtask

  task automatic checkOutput();
    logic [9:0] cur;
    logic [9:0] e;
    if (!clrn) begin
      check("rst_nextdata_n", kb_nextdata_n, 1'b1);
      check("rst_ev_valid", ev_valid, 1'b0);
      check("rst_ev_fields", {ev_code, ev_ext, ev_break}, 10'h000);
      check("rst_held", {held_valid, held_code}, 10'h000);
      check("rst_press_cnt", press_cnt, 0);
      check("rst_sticky", {err_sticky, ovf_sticky}, 2'b00);
      popSeen = 1'b0; prevPop = 1'b0; prevHold = 1'b0; prevXfer = 1'b0;
      return;
    end
    check("press_cnt", press_cnt, mCnt);
    check("held_valid", held_valid, mHeldV);
    if (mHeldV) check("held_code", held_code, mHeld);
    check("err_sticky", err_sticky, mErr);
    check("ovf_sticky", ovf_sticky, mOvf);
    cur = {ev_code, ev_ext, ev_break};
    if (prevXfer) check("ev_valid_drop", ev_valid, 1'b0);
    if (prevHold) begin
      check("ev_valid_hold", ev_valid, 1'b1);
      check("ev_fields_stable", cur, holdFields);
    end
    if (ev_valid) begin
      check("nextdata_while_valid", kb_nextdata_n, 1'b1);
      if (ev_ready) begin
        if (expQ.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_event: got %0h, expected no event", cur);
        end else begin
          e = expQ.pop_front();
          check("event", cur, e);
        end
        evCount++;
        lastEv = cur;
      end
    end
    prevXfer = ev_valid && ev_ready;
    prevHold = ev_valid && !ev_ready;
    holdFields = cur;
    if (prevPop) check("pop_single_cycle", kb_nextdata_n, 1'b1);
    prevPop = !kb_nextdata_n;
    popSeen = !kb_nextdata_n;
  endtask

  // One clock: account for the edge just taken, drive new inputs, then check.
  task automatic applyStimulus();
    logic [7:0] b;
    @(posedge clk); #2;
    if (clrn) begin
      if (clrApplied) begin mErr = 1'b0; mOvf = 1'b0; end
      if (ovfApplied) mOvf = 1'b1;
      if (popSeen) begin
        popCount++;
        checks++;
        if (fifo.size() == 0) begin
          errors++;
          $display("[TB] FAIL pop_while_empty: got pop, expected none");
        end else begin
          b = fifo.pop_front();
          modelByte(b);
        end
      end
    end
    ovfApplied = ovfReq; clrApplied = clrReq;
    kb_overflow = ovfReq; clr_sticky = clrReq;
    ovfReq = 1'b0; clrReq = 1'b0;
    kb_ready = (fifo.size() != 0);
    kb_data = (fifo.size() != 0) ? fifo[0] : 8'h00;
    case (readyMode)
      0: ev_ready = 1'b1;
      1: ev_ready = 1'b0;
      default: ev_ready = 1'($urandom_range(0, 1));
    endcase
    @(negedge clk);
    checkOutput();
  endtask

  task automatic doReset();
    @(posedge clk); #2;
    clrn = 1'b0;
    modelReset();
    kb_ready = 1'b0; kb_data = 8'h00; ev_ready = 1'b0;
    kb_overflow = 1'b0; clr_sticky = 1'b0;
    ovfApplied = 1'b0; clrApplied = 1'b0; ovfReq = 1'b0; clrReq = 1'b0;
    @(negedge clk);
    checkOutput();
    @(posedge clk); #2;
    clrn = 1'b1;
    @(negedge clk);
    checkOutput();
  endtask

  task automatic drain(input int budget);
    int idle = 0;
    int n = 0;
    while (idle < 4 && n < budget) begin
      applyStimulus();
      n++;
      if (fifo.size() == 0 && !ev_valid) idle++;
      else idle = 0;
    end
    check("drain_done", (idle >= 4), 1'b1);
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    int ev0, pop0, lat;
    logic [CNT_W-1:0] cnt0;
    modelReset();
    doReset();

    // Make then break of 1C.
    readyMode = 0;
    ev0 = evCount; pop0 = popCount;
    fifo.push_back(8'h1C);
    drain(40);
    check("t1_held_after_make", {held_valid, held_code}, 10'h21C);
    check("t1_cnt_after_make", press_cnt, 1);
    fifo.push_back(8'hF0); fifo.push_back(8'h1C);
    drain(40);
    check("t1_events", evCount - ev0, 2);
    check("t1_pops", popCount - pop0, 3);
    check("t1_last_event", lastEv, {8'h1C, 1'b0, 1'b1});
    check("t1_held_after_break", held_valid, 1'b0);
    check("t1_cnt_final", press_cnt, 1);

    // Extended key, both prefix orders.
    fifo.push_back(8'hE0); fifo.push_back(8'h75);
    drain(40);
    check("t2_make", lastEv, {8'h75, 1'b1, 1'b0});
    check("t2_held", {held_valid, held_code}, 10'h375);
    fifo.push_back(8'hE0); fifo.push_back(8'hF0); fifo.push_back(8'h75);
    drain(40);
    check("t2_break", lastEv, {8'h75, 1'b1, 1'b1});
    check("t2_released", held_valid, 1'b0);
    fifo.push_back(8'hF0); fifo.push_back(8'hE0); fifo.push_back(8'h6B);
    drain(40);
    check("t2_f0e0_order", lastEv, {8'h6B, 1'b1, 1'b1});

    // Typematic repeats are dropped.
    ev0 = evCount; cnt0 = press_cnt;
    foreach (byteTable[i]) if (i < 3) fifo.push_back(8'h1C);
    fifo.push_back(8'hF0); fifo.push_back(8'h1C);
    drain(60);
    check("t3_events", evCount - ev0, 2);
    check("t3_cnt_delta", CNT_W'(press_cnt - cnt0), 1);

    // Latency and back-pressure.
    readyMode = 1;
    ev0 = evCount; pop0 = popCount; cnt0 = press_cnt;
    fifo.push_back(8'h1B);
    applyStimulus();
    lat = 0;
    while (!ev_valid && lat < 10) begin
      applyStimulus();
      lat++;
    end
    check("t4_latency", lat, 2);
    fifo.push_back(8'h23); fifo.push_back(8'h2B);
    runCycles(15);
    check("t4_pops_stalled", popCount - pop0, 1);
    check("t4_fifo_left", fifo.size(), 2);
    check("t4_ev_pending", {ev_valid, ev_code, ev_ext, ev_break}, {1'b1, 8'h1B, 1'b0, 1'b0});
    readyMode = 0;
    drain(60);
    check("t4_events", evCount - ev0, 3);
    check("t4_last", lastEv, {8'h2B, 1'b0, 1'b0});
    check("t4_cnt_delta", CNT_W'(press_cnt - cnt0), 3);

    // Error byte discards the break prefix; sticky flags set and clear.
    fifo.push_back(8'hF0); fifo.push_back(8'hFF); fifo.push_back(8'h1C);
    drain(60);
    check("t5_err", err_sticky, 1'b1);
    check("t5_event", lastEv, {8'h1C, 1'b0, 1'b0});
    ovfReq = 1'b1;
    runCycles(2);
    check("t5_ovf", ovf_sticky, 1'b1);
    clrReq = 1'b1;
    runCycles(2);
    check("t5_cleared", {err_sticky, ovf_sticky}, 2'b00);

    // Randomized traffic with random consumer stalls.
    readyMode = 2;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0 && fifo.size() < 8)
        fifo.push_back(byteTable[$urandom_range(0, 11)]);
      if ($urandom_range(0, 63) == 0) ovfReq = 1'b1;
      if ($urandom_range(0, 31) == 0) clrReq = 1'b1;
      applyStimulus();
    end
    readyMode = 0;
    drain(200);

    // Counter wrap after 255 presses.
    doReset();
    for (int i = 0; i < 255; i++) begin
      fifo.push_back(8'h1C); fifo.push_back(8'hF0); fifo.push_back(8'h1C);
      drain(60);
    end
    check("t6_cnt_255", press_cnt, 8'hFF);
    fifo.push_back(8'h1C);
    drain(40);
    check("t6_cnt_wrap", press_cnt, 8'h00);

    // Reset in the middle of an E0 prefix.
    fifo.push_back(8'hE0);
    drain(40);
    doReset();
    fifo.push_back(8'h1C);
    drain(40);
    check("t7_after_reset", lastEv, {8'h1C, 1'b0, 1'b0});
    check("t7_cnt", press_cnt, 1);

    check("exp_queue_empty", expQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
